// File: rtl/cal_pkg.sv
// Shared calendar types, constants and the month-length lookup.
package cal_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [4:0] MONTH_MIN = 5'd1;
  localparam logic [4:0] MONTH_MAX = 5'd12;
  localparam logic [4:0] DAYS_31   = 5'd31;
  localparam logic [4:0] DAYS_30   = 5'd30;
  localparam logic [4:0] DAYS_29   = 5'd29;
  localparam logic [4:0] DAYS_28   = 5'd28;

  // Month is given as a BCD pair; result is a plain binary day count.
  function automatic logic [4:0] days_in_month(input bcd_t monthTens, input bcd_t monthOnes,
                                               input logic leap);
    logic [4:0] month;
    month = 5'(monthTens) * 5'd10 + 5'(monthOnes);
    case (month)
      5'd2:                     days_in_month = leap ? DAYS_29 : DAYS_28;
      5'd4, 5'd6, 5'd9, 5'd11:  days_in_month = DAYS_30;
      default:                  days_in_month = DAYS_31;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides ADC_CLK_10 down to a one-cycle day tick; divider selectable on the fly.
module tick_prescaler #(
  parameter int unsigned DIV_SLOW = 10000000,
  parameter int unsigned DIV_FAST = 1000000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic ADC_CLK_10,
  input  logic reset_n,
  input  logic hold,
  input  logic fast_sel,
  output logic tick
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limitM1;
  logic             atLimit;

  assign limitM1 = fast_sel ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);
  // >= so that switching to the shorter divider mid-count wraps immediately
  assign atLimit = (count >= limitM1);
  assign tick    = !hold && atLimit;

  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!hold) begin
      count <= atLimit ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/calendar_date_counter.sv
// Month/day BCD calendar advanced by a prescaled day tick.
// Optional year digits and year-based leap rule when CAL_YEAR_EN is defined.
module calendar_date_counter
  import cal_pkg::*;
#(
  parameter int unsigned DIV_SLOW = 10000000,
  parameter int unsigned DIV_FAST = 1000000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic       ADC_CLK_10,
  input  logic       reset_n,
  input  logic       hold,
  input  logic       fast_sel,
  input  logic       leap_year,
  output logic [3:0] day_ones,
  output logic [3:0] day_tens,
  output logic [3:0] month_ones,
  output logic [3:0] month_tens,
`ifdef CAL_YEAR_EN
  output logic [3:0] year_ones,
  output logic [3:0] year_tens,
`endif
  output logic       day_tick,
  output logic       year_wrap
);

  logic       tick;
  logic       leapEff;
  logic [4:0] dayBin;
  logic [4:0] monthBin;
  logic [4:0] monthLen;
  logic       endOfMonth;
  logic       monthIsDec;

  tick_prescaler #(
    .DIV_SLOW (DIV_SLOW),
    .DIV_FAST (DIV_FAST),
    .CNT_W    (CNT_W)
  ) uPrescaler (
    .ADC_CLK_10 (ADC_CLK_10),
    .reset_n    (reset_n),
    .hold       (hold),
    .fast_sel   (fast_sel),
    .tick       (tick)
  );

`ifdef CAL_YEAR_EN
  logic yearDiv4;
  // Divisible by 4: even tens need ones in {0,4,8}, odd tens need ones in {2,6}
  assign yearDiv4 = year_tens[0] ? (year_ones == 4'd2 || year_ones == 4'd6)
                                 : (year_ones == 4'd0 || year_ones == 4'd4 || year_ones == 4'd8);
  assign leapEff  = leap_year | yearDiv4;
`else
  assign leapEff  = leap_year;
`endif

  assign dayBin     = 5'(day_tens) * 5'd10 + 5'(day_ones);
  assign monthBin   = 5'(month_tens) * 5'd10 + 5'(month_ones);
  assign monthLen   = days_in_month(month_tens, month_ones, leapEff);
  // >= also recovers an out-of-range day (e.g. Feb 29 after leap cleared)
  assign endOfMonth = (dayBin >= monthLen);
  assign monthIsDec = (monthBin == MONTH_MAX);

  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      day_ones   <= 4'd1;
      day_tens   <= 4'd0;
      month_ones <= 4'(MONTH_MIN);
      month_tens <= 4'd0;
      day_tick   <= 1'b0;
      year_wrap  <= 1'b0;
    end else begin
      day_tick  <= 1'b0;
      year_wrap <= 1'b0;
      if (tick) begin
        day_tick <= 1'b1;
        if (endOfMonth) begin
          day_ones <= 4'd1;
          day_tens <= 4'd0;
          if (monthIsDec) begin
            month_ones <= 4'(MONTH_MIN);
            month_tens <= 4'd0;
            year_wrap  <= 1'b1;
          end else if (month_ones == 4'd9) begin
            month_ones <= 4'd0;
            month_tens <= month_tens + 4'd1;
          end else begin
            month_ones <= month_ones + 4'd1;
          end
        end else if (day_ones == 4'd9) begin
          day_ones <= 4'd0;
          day_tens <= day_tens + 4'd1;
        end else begin
          day_ones <= day_ones + 4'd1;
        end
      end
    end
  end

`ifdef CAL_YEAR_EN
  // Year advances on the same edge that raises year_wrap; 99 rolls to 00
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      year_ones <= 4'd0;
      year_tens <= 4'd0;
    end else if (tick && endOfMonth && monthIsDec) begin
      if (year_ones == 4'd9) begin
        year_ones <= 4'd0;
        year_tens <= (year_tens == 4'd9) ? 4'd0 : year_tens + 4'd1;
      end else begin
        year_ones <= year_ones + 4'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_calendar_date_counter.sv
// Self-checking bench for calendar_date_counter with a small divider set.
module tb_calendar_date_counter;

  localparam int unsigned DS = 4;
  localparam int unsigned DF = 2;

  logic       clk;
  logic       reset_n;
  logic       hold;
  logic       fast_sel;
  logic       leap_year;
  logic [3:0] day_ones, day_tens, month_ones, month_tens;
  logic       day_tick, year_wrap;

  int passCnt;
  int checkCnt;

  // Reference model state
  int mCnt, mMonth, mDay;
  bit mTick, mWrap;

  calendar_date_counter #(
    .DIV_SLOW (DS),
    .DIV_FAST (DF),
    .CNT_W    (24)
  ) dut (
    .ADC_CLK_10 (clk),
    .reset_n    (reset_n),
    .hold       (hold),
    .fast_sel   (fast_sel),
    .leap_year  (leap_year),
    .day_ones   (day_ones),
    .day_tens   (day_tens),
    .month_ones (month_ones),
    .month_tens (month_tens),
    .day_tick   (day_tick),
    .year_wrap  (year_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int monthDays(int m, bit leap);
    int tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && leap) return 29;
    return tbl[m-1];
  endfunction

  function automatic logic [15:0] expDate();
    return {4'(mMonth / 10), 4'(mMonth % 10), 4'(mDay / 10), 4'(mDay % 10)};
  endfunction

  function automatic logic [15:0] dutDate();
    return {month_tens, month_ones, day_tens, day_ones};
  endfunction

  task automatic modelReset();
    mCnt = 0; mMonth = 1; mDay = 1; mTick = 0; mWrap = 0;
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then settle
  task automatic clkStep();
    int lim;
    @(posedge clk);
    mTick = 0; mWrap = 0;
    if (!hold) begin
      lim = fast_sel ? DF : DS;
      if (mCnt >= lim - 1) begin mCnt = 0; mTick = 1; end
      else mCnt++;
    end
    if (mTick) begin
      if (mDay >= monthDays(mMonth, leap_year)) begin
        mDay = 1;
        if (mMonth == 12) begin mMonth = 1; mWrap = 1; end
        else mMonth++;
      end else mDay++;
    end
    #1;
  endtask

  task automatic runToDate(int m, int d, output bit ok);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      clkStep();
      if (mTick && mMonth == m && mDay == d) begin ok = 1; return; end
    end
  endtask

  task automatic runToTick(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      clkStep();
      if (mTick) begin ok = 1; return; end
    end
  endtask

  task automatic test_reset();
    reset_n = 0; hold = 0; fast_sel = 0; leap_year = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkCnt++;
      if (dutDate() !== 16'h0101 || {day_tick, year_wrap} !== 2'b00)
        $display("FAIL reset_hold date=%h pulses=%b exp date=0101 pulses=00", dutDate(), {day_tick, year_wrap});
      else passCnt++;
    end
    reset_n = 1;
    modelReset();
    for (int e = 1; e <= 4; e++) begin
      clkStep();
      checkCnt++;
      if (day_tick !== 1'(e == 4))
        $display("FAIL first_tick edge=%0d day_tick=%b exp=%b", e, day_tick, 1'(e == 4));
      else passCnt++;
    end
    checkCnt++;
    if (dutDate() !== 16'h0102) $display("FAIL first_date got=%h exp=0102", dutDate());
    else passCnt++;
  endtask

  task automatic test_jan_feb();
    bit ok;
    fast_sel = 1;
    runToDate(1, 31, ok);
    checkCnt++;
    if (!ok || dutDate() !== 16'h0131) $display("FAIL reach_0131 ok=%0d got=%h exp=0131", ok, dutDate());
    else passCnt++;
    runToTick(ok);
    checkCnt++;
    if (!ok || dutDate() !== 16'h0201 || {day_tick, year_wrap} !== 2'b10)
      $display("FAIL jan_to_feb got=%h pulses=%b exp=0201 pulses=10", dutDate(), {day_tick, year_wrap});
    else passCnt++;
  endtask

  task automatic test_feb_noleap();
    bit ok;
    leap_year = 0;
    runToDate(2, 28, ok);
    runToTick(ok);
    checkCnt++;
    if (!ok || dutDate() !== 16'h0301) $display("FAIL feb_noleap got=%h exp=0301", dutDate());
    else passCnt++;
  endtask

  task automatic test_sep_oct();
    bit ok;
    runToDate(9, 30, ok);
    checkCnt++;
    if (!ok || dutDate() !== 16'h0930) $display("FAIL reach_0930 got=%h exp=0930", dutDate());
    else passCnt++;
    runToTick(ok);
    checkCnt++;
    if (!ok || dutDate() !== 16'h1001) $display("FAIL sep_to_oct got=%h exp=1001", dutDate());
    else passCnt++;
  endtask

  task automatic test_year_wrap();
    bit ok;
    bit reached;
    reached = 0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      clkStep();
      if (mTick) begin
        checkCnt++;
        if (year_wrap !== 1'b0 || day_tick !== 1'b1)
          $display("FAIL no_wrap_tick date=%h year_wrap=%b day_tick=%b exp 0/1", dutDate(), year_wrap, day_tick);
        else passCnt++;
      end
      if (mMonth == 12 && mDay == 31) reached = 1;
    end
    runToTick(ok);
    checkCnt++;
    if (!reached || !ok || dutDate() !== 16'h0101 || {day_tick, year_wrap} !== 2'b11)
      $display("FAIL dec_to_jan got=%h pulses=%b exp=0101 pulses=11", dutDate(), {day_tick, year_wrap});
    else passCnt++;
    clkStep();
    checkCnt++;
    if ({day_tick, year_wrap} !== 2'b00)
      $display("FAIL wrap_one_cycle pulses=%b exp=00", {day_tick, year_wrap});
    else passCnt++;
  endtask

  task automatic test_leap();
    bit ok;
    leap_year = 1;
    runToDate(2, 28, ok);
    runToTick(ok);
    checkCnt++;
    if (!ok || dutDate() !== 16'h0229) $display("FAIL leap_0229 got=%h exp=0229", dutDate());
    else passCnt++;
    runToTick(ok);
    checkCnt++;
    if (!ok || dutDate() !== 16'h0301) $display("FAIL leap_0301 got=%h exp=0301", dutDate());
    else passCnt++;
  endtask

  task automatic test_hold();
    logic [15:0] frozen;
    bit found;
    fast_sel = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      clkStep();
      if (mCnt == 1) found = 1;
    end
    frozen = dutDate();
    hold = 1;
    for (int i = 0; i < 10; i++) begin
      clkStep();
      checkCnt++;
      if (!found || dutDate() !== frozen || {day_tick, year_wrap} !== 2'b00)
        $display("FAIL hold_frozen cyc=%0d got=%h pulses=%b exp=%h pulses=00", i, dutDate(), {day_tick, year_wrap}, frozen);
      else passCnt++;
    end
    hold = 0;
    for (int k = 0; k < 3; k++) begin
      clkStep();
      checkCnt++;
      if (day_tick !== 1'(k == 2) || dutDate() !== expDate())
        $display("FAIL hold_resume k=%0d day_tick=%b date=%h exp tick=%b date=%h", k, day_tick, dutDate(), 1'(k == 2), expDate());
      else passCnt++;
    end
  endtask

  task automatic test_fast_switch();
    bit found;
    found = 0;
    fast_sel = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      clkStep();
      if (mCnt == 2) found = 1;
    end
    fast_sel = 1;
    for (int k = 0; k < 5; k++) begin
      clkStep();
      checkCnt++;
      if (!found || day_tick !== 1'(k % 2 == 0) || dutDate() !== expDate())
        $display("FAIL fast_switch k=%0d day_tick=%b date=%h exp tick=%b date=%h", k, day_tick, dutDate(), 1'(k % 2 == 0), expDate());
      else passCnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) fast_sel = ~fast_sel;
      if ($urandom_range(0, 63) == 0) leap_year = 1'($urandom_range(0, 1));
      clkStep();
      checkCnt++;
      if (dutDate() !== expDate() || {day_tick, year_wrap} !== {mTick, mWrap})
        $display("FAIL random cyc=%0d date=%h pulses=%b exp date=%h pulses=%b", i, dutDate(), {day_tick, year_wrap}, expDate(), {mTick, mWrap});
      else passCnt++;
    end
    hold = 0;
  endtask

  task automatic test_async_reset();
    bit ok;
    fast_sel = 1;
    runToDate(7, 15, ok);
    checkCnt++;
    if (!ok || dutDate() !== 16'h0715) $display("FAIL reach_0715 got=%h exp=0715", dutDate());
    else passCnt++;
    @(negedge clk);
    reset_n = 0;
    #1;
    checkCnt++;
    if (dutDate() !== 16'h0101 || {day_tick, year_wrap} !== 2'b00)
      $display("FAIL async_reset got=%h pulses=%b exp=0101 pulses=00", dutDate(), {day_tick, year_wrap});
    else passCnt++;
    #1;
    reset_n = 1;
    fast_sel = 0;
    modelReset();
    for (int e = 1; e <= 4; e++) begin
      clkStep();
      checkCnt++;
      if (day_tick !== 1'(e == 4) || dutDate() !== expDate())
        $display("FAIL restart edge=%0d day_tick=%b date=%h exp tick=%b date=%h", e, day_tick, dutDate(), 1'(e == 4), expDate());
      else passCnt++;
    end
  endtask

  initial begin
    passCnt = 0;
    checkCnt = 0;
    modelReset();
    test_reset();
    test_jan_feb();
    test_feb_noleap();
    test_sep_oct();
    test_year_wrap();
    test_leap();
    test_hold();
    test_fast_switch();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
